// File: rtl/pc_seq_pkg.sv
// Shared types and widths for the PC sequencer.
package pc_seq_pkg;
    localparam int PC_W  = 16;
    localparam int IMM_W = 12;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_t;
endpackage

// File: rtl/append_buffer.sv
// Splices the upper PC page onto a 12-bit immediate to form an absolute jump target.
module Append_Buffer
    import pc_seq_pkg::*;
(
    input  logic [PC_W-IMM_W-1:0] Upper_4_PC,
    input  logic [IMM_W-1:0]      Lower_12_Imm,
    output logic [PC_W-1:0]       Appended_PC
);
    assign Appended_PC = {Upper_4_PC, Lower_12_Imm};
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: increment, jump/branch redirect, and a fixed-length flush window.
// Optional feature macro: PC_SEQ_ALIGN_CHECK_EN (sticky misaligned-target flag, target bit0 cleared).
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000,
    parameter int              PC_STEP      = 2,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Stall,
    input  logic              Jump_Req,
    input  logic [IMM_W-1:0]  Jump_Imm,
    input  logic              Branch_Req,
    input  logic              Branch_Taken,
    input  logic [PC_W-1:0]   Branch_Offset,
    output logic [PC_W-1:0]   PC_Out,
    output logic              Fetch_Valid,
    output logic              Flush,
    output logic              Redirect_Ack,
    output logic              Align_Err
);
    localparam logic [PC_W-1:0] STEP       = PC_W'(PC_STEP);
    localparam logic [2:0]      FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    seq_state_t      state, state_nxt;
    logic [2:0]      flush_cnt, flush_cnt_nxt;
    logic            take_jump, take_branch, redirect;
    logic [PC_W-1:0] jump_tgt, branch_tgt, raw_tgt, tgt, pc_nxt;

    Append_Buffer u_append (
        .Upper_4_PC  (PC_Out[PC_W-1:IMM_W]),
        .Lower_12_Imm(Jump_Imm),
        .Appended_PC (jump_tgt)
    );

    assign branch_tgt  = PC_Out + Branch_Offset;
    // Jump outranks a simultaneous taken branch; the branch is simply dropped.
    assign take_jump   = (state == RUN) && !Stall && Jump_Req;
    assign take_branch = (state == RUN) && !Stall && Branch_Req && Branch_Taken && !Jump_Req;
    assign redirect    = take_jump || take_branch;
    assign raw_tgt     = take_jump ? jump_tgt : branch_tgt;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign tgt = {raw_tgt[PC_W-1:1], 1'b0};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            Align_Err <= 1'b0;
        else if (redirect && raw_tgt[0])
            Align_Err <= 1'b1;
    end
`else
    assign tgt       = raw_tgt;
    assign Align_Err = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            flush_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Next-state logic; stall freezes both the state and the flush counter.
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (!Stall) begin
            case (state)
                RUN: if (redirect) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = 3'd0;
                end
                FLUSH: if (flush_cnt == FLUSH_LAST) begin
                    state_nxt     = RUN;
                    flush_cnt_nxt = 3'd0;
                end else begin
                    flush_cnt_nxt = flush_cnt + 3'd1;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Outputs; reset masks the handshake outputs while state is being forced.
    always_comb begin
        Fetch_Valid  = !RST && (state == RUN) && !Stall;
        Redirect_Ack = !RST && redirect;
        Flush        = (state == FLUSH);
    end

    always_comb begin
        pc_nxt = PC_Out;
        if (redirect)
            pc_nxt = tgt;
        else if (!Stall && (state == RUN))
            pc_nxt = PC_Out + STEP;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            PC_Out <= RESET_VECTOR;
        else
            PC_Out <= pc_nxt;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 16'h0000: PC value loaded on reset.
REQ-002 Parameter PC_STEP, default 2: sequential PC increment.
REQ-003 Parameter FLUSH_CYCLES, default 2: FLUSH state length in cycles, range 1-7.
REQ-004 CLK  in  1: sole clock; all state updates on rising edge.
REQ-005 RST  in  1: asynchronous, active-high reset.
REQ-006 Stall  in  1: freeze PC and FSM.
REQ-007 Jump_Req  in  1: absolute jump request, level, held until acknowledged.
REQ-008 Jump_Imm  in  12: jump target low 12 bits.
REQ-009 Branch_Req  in  1: branch resolved this cycle.
REQ-010 Branch_Taken  in  1: branch outcome, qualified by Branch_Req.
REQ-011 Branch_Offset  in  16: signed, pre-extended PC-relative offset.
REQ-012 PC_Out  out  16: current fetch address (register output).
REQ-013 Fetch_Valid  out  1: PC_Out is a valid fetch this cycle.
REQ-014 Flush  out  1: squash younger pipeline instructions.
REQ-015 Redirect_Ack  out  1: one-cycle pulse when a jump or taken branch is accepted.
REQ-016 Align_Err  out  1: sticky misaligned-target flag (see Configuration).

Function
REQ-017 The FSM SHALL have states RUN and FLUSH.
REQ-018 In RUN with Stall=0 and no redirect, PC_Out SHALL become PC_Out+PC_STEP next cycle, wrapping modulo 2^16 (16'hFFFE+2 -> 16'h0000).
REQ-019 Jump target SHALL be {PC_Out[15:12], Jump_Imm}, using the PC_Out of the accepting cycle.
REQ-020 Branch target SHALL be PC_Out+Branch_Offset, truncated to 16 bits (wraps both directions).
REQ-021 In RUN with Stall=0, Jump_Req=1 SHALL be accepted: PC_Out<=jump target, Redirect_Ack=1 that cycle, next state FLUSH.
REQ-022 In RUN with Stall=0, Branch_Req=1 & Branch_Taken=1 & Jump_Req=0 SHALL be accepted the same way using the branch target.
REQ-023 Simultaneous jump and taken branch: jump wins; the branch is dropped without acknowledge.
REQ-024 Branch_Req=1 with Branch_Taken=0 SHALL act as a normal increment; no ack, no flush.
REQ-025 FLUSH SHALL last exactly FLUSH_CYCLES non-stalled cycles: Flush=1, Fetch_Valid=0, PC_Out held at target, then return to RUN.
REQ-026 Requests arriving in FLUSH SHALL be ignored and unacknowledged; a held Jump_Req is accepted on the first RUN cycle.
REQ-027 Stall=1 SHALL hold PC_Out, state and flush counter, force Redirect_Ack=0 and Fetch_Valid=0, and leave Flush at its pre-stall value.
REQ-028 Fetch_Valid SHALL be 1 in RUN when Stall=0, otherwise 0.
REQ-029 Redirect_Ack, Flush and Fetch_Valid SHALL be combinational from state and inputs; PC_Out and Align_Err SHALL be registered.

Reset
REQ-030 RST=1 SHALL immediately force PC_Out=RESET_VECTOR, state=RUN, flush counter=0, Align_Err=0, without waiting for a clock edge.
REQ-031 Reset asserted mid-FLUSH SHALL abandon the flush; after release, Flush=0.
REQ-032 During reset, Fetch_Valid=0 and Redirect_Ack=0.

Configuration
REQ-033 Macro PC_SEQ_ALIGN_CHECK_EN defined: an accepted target with bit0=1 SHALL set Align_Err (sticky until reset), and the target's bit0 SHALL be forced to 0.
REQ-034 Macro PC_SEQ_ALIGN_CHECK_EN undefined: Align_Err SHALL be tied 0 and targets used unmodified.

Structure
REQ-035 Shared package pc_seq_pkg SHALL hold the state encoding (RUN=1'b0, FLUSH=1'b1), the PC width constant 16, and the immediate width constant 12.
REQ-036 Jump-target formation SHALL instantiate the existing Append_Buffer (Upper_4_PC=PC_Out[15:12], Lower_12_Imm=Jump_Imm); no other sub-module.

Verification
REQ-037 Release reset, no requests, 4 cycles -> PC_Out 0000, 0002, 0004, 0006, with Fetch_Valid=1.
REQ-038 PC_Out=16'h4100, Jump_Req=1, Jump_Imm=12'h567 -> Redirect_Ack pulses, PC_Out=16'h4567, Flush=1 for 2 cycles, then 4569.
REQ-039 PC_Out=16'h0010, Branch_Taken=1 with offset 16'hFFF0 -> PC_Out=16'h0000 and flush; same cycle with Jump_Req=1, Jump_Imm=12'h020 -> PC_Out=16'h0020, branch ignored.
REQ-040 Stall=1 for 3 cycles mid-FLUSH -> PC_Out, Flush and the counter frozen, Fetch_Valid=0; 2 flush cycles total after release.
REQ-041 RST pulse between clock edges during FLUSH -> PC_Out=RESET_VECTOR immediately, Flush=0 after release.
REQ-042 With PC_SEQ_ALIGN_CHECK_EN defined, jump to Jump_Imm=12'h123 from 16'h8000 -> PC_Out=16'h8122, Align_Err=1 held until reset.
